// File: rtl/mod6_sequence_checker.sv
// rtl/mod6_sequence_checker.sv - mod-6 count stream checker; optional error_sticky output under MOD6_CHK_STICKY_EN
module mod6_sequence_checker #(
    parameter int LOCK_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    input  logic [3:0]       Yt,
    output logic             locked,
    output logic             error,
    output logic             illegal,
    output logic [3:0]       expected,
    output logic [CNT_W-1:0] err_count,
`ifdef MOD6_CHK_STICKY_EN
    output logic             error_sticky,
`endif
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_LEN);

    state_t     state;
    logic [3:0] prev;
    logic [3:0] run;
    logic [3:0] run_nxt;
    logic [3:0] succ_prev;
    logic [3:0] succ_yt;
    logic       legal;
    logic       match;
    logic       viol;

    function automatic logic [3:0] succ(input logic [3:0] p);
        return (p == 4'd5) ? 4'd0 : p + 4'd1;
    endfunction

    always_comb begin
        succ_prev = succ(prev);
        succ_yt   = succ(Yt);
        legal     = (Yt <= 4'd5);
        match     = (Yt == succ_prev);
        run_nxt   = run + 4'd1;
        // Any sample that pulses error or illegal this cycle
        viol      = valid && (!legal || (state == LOCKED && !match));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            prev        <= 4'd0;
            run         <= 4'd0;
            locked      <= 1'b0;
            error       <= 1'b0;
            illegal     <= 1'b0;
            expected    <= 4'd0;
            err_count   <= '0;
            cycle_count <= '0;
        end else begin
            error   <= 1'b0;
            illegal <= 1'b0;
            if (valid) begin
                case (state)
                    HUNT: begin
                        if (legal) begin
                            prev     <= Yt;
                            run      <= 4'd0;
                            expected <= succ_yt;
                            state    <= VERIFY;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (!legal) begin
                            illegal  <= 1'b1;
                            run      <= 4'd0;
                            expected <= 4'd0;
                            state    <= HUNT;
                        end else if (match) begin
                            prev     <= Yt;
                            expected <= succ_yt;
                            if (run_nxt == LOCK_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= 4'd0;
                            end else begin
                                run <= run_nxt;
                            end
                        end else begin
                            prev     <= Yt;
                            run      <= 4'd0;
                            expected <= succ_yt;
                        end
                    end
                    LOCKED: begin
                        if (legal && match) begin
                            prev     <= Yt;
                            expected <= succ_yt;
                            if (prev == 4'd5)
                                cycle_count <= cycle_count + CNT_W'(1);
                        end else begin
                            error  <= 1'b1;
                            locked <= 1'b0;
                            run    <= 4'd0;
                            if (err_count != '1)
                                err_count <= err_count + CNT_W'(1);
                            if (legal) begin
                                // Resync starts from the offending value itself
                                prev     <= Yt;
                                expected <= succ_yt;
                                state    <= VERIFY;
                            end else begin
                                illegal  <= 1'b1;
                                expected <= 4'd0;
                                state    <= HUNT;
                            end
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        expected <= 4'd0;
                    end
                endcase
            end
        end
    end

`ifdef MOD6_CHK_STICKY_EN
    always_ff @(posedge clock) begin
        if (reset)
            error_sticky <= 1'b0;
        else if (viol)
            error_sticky <= 1'b1;
    end
`else
    logic unused_viol;
    assign unused_viol = viol;
`endif

endmodule

// File: tb/tb_mod6_sequence_checker.sv
// tb/tb_mod6_sequence_checker.sv - scoreboard bench for mod6_sequence_checker (CNT_W=2, LOCK_LEN=3)
module tb_mod6_sequence_checker;

    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          valid = 1'b0;
    logic [3:0]    Yt    = 4'd0;
    logic          locked;
    logic          error;
    logic          illegal;
    logic [3:0]    expected;
    logic [CW-1:0] err_count;
    logic [CW-1:0] cycle_count;
`ifdef MOD6_CHK_STICKY_EN
    logic          error_sticky;
`endif

    always #5 clock = ~clock;

    mod6_sequence_checker #(.LOCK_LEN(3), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .Yt          (Yt),
        .locked      (locked),
        .error       (error),
        .illegal     (illegal),
        .expected    (expected),
        .err_count   (err_count),
`ifdef MOD6_CHK_STICKY_EN
        .error_sticky(error_sticky),
`endif
        .cycle_count (cycle_count)
    );

    typedef struct packed {
        logic          lk;
        logic          er;
        logic          il;
        logic [3:0]    ex;
        logic [CW-1:0] ec;
        logic [CW-1:0] cc;
        logic          stk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    logic stk_model = 1'b0;

    task automatic step(input logic r, input logic v, input logic [3:0] y,
                        input logic lk, input logic er, input logic il,
                        input logic [3:0] ex, input int ec, input int cc);
        exp_t e;
        @(negedge clock);
        reset = r;
        valid = v;
        Yt    = y;
        if (r)
            stk_model = 1'b0;
        else if (er || il)
            stk_model = 1'b1;
        e.lk  = lk;
        e.er  = er;
        e.il  = il;
        e.ex  = ex;
        e.ec  = CW'(ec);
        e.cc  = CW'(cc);
        e.stk = stk_model;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        int   id;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                id = vec_id;
                vec_id++;
                a.lk  = locked;
                a.er  = error;
                a.il  = illegal;
                a.ex  = expected;
                a.ec  = err_count;
                a.cc  = cycle_count;
`ifdef MOD6_CHK_STICKY_EN
                a.stk = error_sticky;
`else
                a.stk = e.stk;
`endif
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL vec%0d: got lk=%b er=%b il=%b ex=%0d ec=%0d cc=%0d stk=%b want lk=%b er=%b il=%b ex=%0d ec=%0d cc=%0d stk=%b",
                             id, a.lk, a.er, a.il, a.ex, a.ec, a.cc, a.stk,
                             e.lk, e.er, e.il, e.ex, e.ec, e.cc, e.stk);
                end
            end
        end
    end

    initial begin : stimulus
        //   r  v  Yt    lk er il ex ec cc
        step(1, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        // lock from generator power-up value 5
        step(0, 1, 4'd5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'd0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 4'd1, 0, 0, 0, 2, 0, 0);
        step(0, 1, 4'd2, 1, 0, 0, 3, 0, 0);
        step(0, 1, 4'd3, 1, 0, 0, 4, 0, 0);
        step(0, 1, 4'd4, 1, 0, 0, 5, 0, 0);
        step(0, 1, 4'd5, 1, 0, 0, 0, 0, 0);
        step(0, 1, 4'd0, 1, 0, 0, 1, 0, 1);
        step(0, 1, 4'd1, 1, 0, 0, 2, 0, 1);
        step(0, 1, 4'd2, 1, 0, 0, 3, 0, 1);
        step(0, 1, 4'd3, 1, 0, 0, 4, 0, 1);
        // dropped 4, then relock
        step(0, 1, 4'd5, 0, 1, 0, 0, 1, 1);
        step(0, 1, 4'd0, 0, 0, 0, 1, 1, 1);
        step(0, 1, 4'd1, 0, 0, 0, 2, 1, 1);
        step(0, 1, 4'd2, 1, 0, 0, 3, 1, 1);
        // valid gap with garbage
        step(0, 0, 4'd9, 1, 0, 0, 3, 1, 1);
        step(0, 0, 4'd7, 1, 0, 0, 3, 1, 1);
        step(0, 0, 4'd0, 1, 0, 0, 3, 1, 1);
        step(0, 0, 4'd15,1, 0, 0, 3, 1, 1);
        step(0, 0, 4'd2, 1, 0, 0, 3, 1, 1);
        step(0, 1, 4'd3, 1, 0, 0, 4, 1, 1);
        // illegal while locked, then illegal in HUNT
        step(0, 1, 4'd7, 0, 1, 1, 0, 2, 1);
        step(0, 1, 4'd9, 0, 0, 1, 0, 2, 1);
        // repeat in VERIFY is silent
        step(0, 1, 4'd4, 0, 0, 0, 5, 2, 1);
        step(0, 1, 4'd4, 0, 0, 0, 5, 2, 1);
        step(0, 1, 4'd5, 0, 0, 0, 0, 2, 1);
        step(0, 1, 4'd0, 0, 0, 0, 1, 2, 1);
        step(0, 1, 4'd1, 1, 0, 0, 2, 2, 1);
        step(0, 1, 4'd2, 1, 0, 0, 3, 2, 1);
        // repeat while locked
        step(0, 1, 4'd2, 0, 1, 0, 3, 3, 1);
        step(0, 1, 4'd3, 0, 0, 0, 4, 3, 1);
        step(0, 1, 4'd4, 0, 0, 0, 5, 3, 1);
        step(0, 1, 4'd5, 1, 0, 0, 0, 3, 1);
        step(0, 1, 4'd0, 1, 0, 0, 1, 3, 2);
        // out-of-order with err_count saturated
        step(0, 1, 4'd3, 0, 1, 0, 4, 3, 2);
        step(0, 1, 4'd4, 0, 0, 0, 5, 3, 2);
        step(0, 1, 4'd5, 0, 0, 0, 0, 3, 2);
        step(0, 1, 4'd0, 1, 0, 0, 1, 3, 2);
        step(0, 1, 4'd14,0, 1, 1, 0, 3, 2);
        // illegal in VERIFY
        step(0, 1, 4'd1, 0, 0, 0, 2, 3, 2);
        step(0, 1, 4'd6, 0, 0, 1, 0, 3, 2);
        // relock and wrap cycle_count
        step(0, 1, 4'd2, 0, 0, 0, 3, 3, 2);
        step(0, 1, 4'd3, 0, 0, 0, 4, 3, 2);
        step(0, 1, 4'd4, 0, 0, 0, 5, 3, 2);
        step(0, 1, 4'd5, 1, 0, 0, 0, 3, 2);
        step(0, 1, 4'd0, 1, 0, 0, 1, 3, 3);
        step(0, 1, 4'd1, 1, 0, 0, 2, 3, 3);
        step(0, 1, 4'd2, 1, 0, 0, 3, 3, 3);
        step(0, 1, 4'd3, 1, 0, 0, 4, 3, 3);
        step(0, 1, 4'd4, 1, 0, 0, 5, 3, 3);
        step(0, 1, 4'd5, 1, 0, 0, 0, 3, 3);
        step(0, 1, 4'd0, 1, 0, 0, 1, 3, 0);
        // reset mid-lock beats a would-be error
        step(1, 1, 4'd9, 0, 0, 0, 0, 0, 0);
        step(0, 0, 4'd1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'd3, 0, 0, 0, 4, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clock);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod6_sequence_checker.md
# mod6_sequence_checker

Receive-side checker for the mod-6 count stream (0→1→2→3→4→5→0…) produced by the team's mod-6 sequence generator. It samples the 4-bit count bus on the rising edge of `clock`, which falls mid-cycle relative to the generator's negedge updates. It locks onto the sequence, then flags dropped, repeated or out-of-order codes and illegal codes 6–15. It keeps saturating error and completed-cycle counters for the test harness.

## Interface
- `LOCK_LEN`, default 3: consecutive correct transitions required to declare lock; legal range 1–15.
- `CNT_W`, default 8: width of `err_count` and `cycle_count`.

- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  sample-enable; when low, `Yt` is ignored.
- `Yt`  in  4  count value from generator; legal codes 0–5.
- `locked`  out  1  level; sequence lock held.
- `error`  out  1  one-cycle pulse; sequence violation while locked.
- `illegal`  out  1  one-cycle pulse; code >5 sampled in any state.
- `expected`  out  4  next code expected; 0 in HUNT.
- `err_count`  out  CNT_W  saturating count of `error` pulses.
- `cycle_count`  out  CNT_W  wrapping count of 5→0 transitions seen while locked.

## Operation
- `succ(p)` = (p==5) ? 0 : p+1.
- Internal state: `prev` (4b), `run` (4b), FSM state.
- The FSM has three states: HUNT, VERIFY and LOCKED.
- HUNT, valid, Yt≤5:
  - `prev`←Yt, `run`←0.
  - Go to VERIFY, or straight to LOCKED if LOCK_LEN==1 is met on the next match.
- HUNT, valid, Yt>5: `illegal` pulse; stay in HUNT.
- VERIFY, valid, Yt==succ(prev):
  - `prev`←Yt, `run`←run+1.
  - If run+1==LOCK_LEN: go to LOCKED, `locked`←1, `run`←0.
- VERIFY, valid, legal mismatch: `prev`←Yt, `run`←0; stay in VERIFY. No `error` pulse and no count change.
- VERIFY, valid, Yt>5: `illegal` pulse; go to HUNT, `run`←0.
- LOCKED, valid, Yt==succ(prev):
  - `prev`←Yt.
  - If prev==5 and Yt==0: `cycle_count`←cycle_count+1 (wraps modulo 2^CNT_W).
- LOCKED, valid, legal mismatch:
  - `error` pulse, `err_count` increments (saturates at all-ones), `locked`←0.
  - `prev`←Yt, `run`←0; go to VERIFY (resync from the offending value).
- LOCKED, valid, Yt>5:
  - `error` and `illegal` both pulse, `err_count` increments (saturating), `locked`←0.
  - Go to HUNT.
- `valid` low in any state: all state held, `error`/`illegal` driven 0. Gaps are not violations.
- A repeated value (Yt==prev) counts as a mismatch.
- The generator's power-up value 5 is a legal start; the first expected code after 5 is 0.

## Timing
- All outputs are registered. A sample on posedge N is reflected on outputs after posedge N.
- `error`/`illegal` are high for exactly one cycle per offending sample.
- `locked` rises in the cycle after the LOCK_LEN-th correct transition. Minimum latency from first valid sample is LOCK_LEN+1 samples.
- `expected` = succ(prev) in VERIFY/LOCKED, updated together with `prev`.
- `reset` has priority over every other input, including mid-lock and mid-pulse. On the posedge where it is sampled high:
  - State→HUNT.
  - `prev`, `run`, `locked`, `error`, `illegal`, `expected`, `err_count`, `cycle_count` all →0.
- `err_count` saturates at 2^CNT_W−1; once saturated, further errors still pulse `error`.

## Configuration
- `MOD6_CHK_STICKY_EN`
  - Defined: adds output `error_sticky` (1b). It sets on any `error` or `illegal` pulse and clears only on `reset`; reset value 0.
  - Undefined: port and logic absent; all other behaviour identical.

## Test plan
- Reset, then valid stream 5,0,1,2,3,4,5,0 with LOCK_LEN=3 → `locked`=1 after the sample "2" (4th sample); `cycle_count`=1 after the final 0; `err_count`=0.
- Locked, stream …2,3,5,0,1,2 (4 dropped) → `error` one pulse after "5", `err_count`=1, `locked`=0; relock after "2" with `expected`=3.
- Locked, inject Yt=7 → `error` and `illegal` pulse in the same cycle, state HUNT, `locked`=0; HUNT, Yt=9 → `illegal` only, `err_count` unchanged.
- Locked, `valid` low for 5 cycles with garbage on Yt, then resume with the correct successor → no pulses, `locked` stays 1.
- CNT_W=2, 5 forced violations with relock between them → `err_count` holds at 3; `reset` asserted mid-lock → all outputs 0 the next cycle.
- With `MOD6_CHK_STICKY_EN`: one violation then a clean relock → `error_sticky` stays 1 until `reset`.
